// File: rtl/sdram_frame_ctrl_pkg.sv
// rtl/sdram_frame_ctrl_pkg.sv - shared state encoding and constants for the SDRAM frame scheduler
package sdram_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    localparam int BUF_BIT = 22;
    localparam int ROW_LSB = 9;
    localparam int ROW_W   = 13;

    localparam int DEF_BURST_LEN      = 512;
    localparam int DEF_ROWS_PER_FRAME = 128;
    localparam int DEF_FIFO_DEPTH     = 1024;
    localparam int DEF_ADDR_W         = 24;

endpackage

// File: rtl/sdram_frame_ctrl_if.sv
// rtl/sdram_frame_ctrl_if.sv - burst request/ack bus between the frame scheduler and sdram_top
interface sdram_frame_ctrl_if #(
    parameter int ADDR_W = 24
) ();

    logic              wr_sdram_req;
    logic              wr_sdram_ack;
    logic [ADDR_W-1:0] wr_sdram_add;
    logic              rd_sdram_req;
    logic              rd_sdram_ack;
    logic [ADDR_W-1:0] rd_sdram_add;

    modport master (
        output wr_sdram_req,
        output wr_sdram_add,
        input  wr_sdram_ack,
        output rd_sdram_req,
        output rd_sdram_add,
        input  rd_sdram_ack
    );

    modport slave (
        input  wr_sdram_req,
        input  wr_sdram_add,
        output wr_sdram_ack,
        input  rd_sdram_req,
        input  rd_sdram_add,
        output rd_sdram_ack
    );

endinterface

// File: rtl/sdram_frame_ctrl_sync_edge_det.sv
// rtl/sdram_frame_ctrl_sync_edge_det.sv - two-flop synchronizer with falling-edge pulse
module sdram_frame_ctrl_sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic fall_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Metastability filter followed by one history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign fall_pulse = prev_q & ~sync_q2;

endmodule

// File: rtl/sdram_frame_ctrl.sv
// rtl/sdram_frame_ctrl.sv - ping-pong frame store scheduler issuing row bursts to sdram_top
module sdram_frame_ctrl
    import sdram_frame_ctrl_pkg::*;
#(
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME,   // at most 8192
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [10:0]         wr_fifo_used,
    input  logic [10:0]         rd_fifo_used,
    input  logic                vsync_i,
    sdram_frame_ctrl_if.master  sdram,
    output logic                frame_valid_o,
    output logic                wr_buf_o,
    output logic                rd_buf_o,
    output logic [15:0]         frame_cnt_o,
    output logic                drop_o
);

    localparam logic [10:0]      WR_THRESH   = 11'(BURST_LEN);
    localparam logic [10:0]      RD_THRESH   = 11'(FIFO_DEPTH - BURST_LEN);
    localparam logic [ROW_W-1:0] WR_ROW_LAST = ROW_W'(ROWS_PER_FRAME - 1);
    localparam logic [ROW_W:0]   RD_ROW_END  = (ROW_W+1)'(ROWS_PER_FRAME);

    state_t           state;
    state_t           state_nxt;
    grant_t           last_grant;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W:0]   rd_row;          // one extra bit so "all rows read" is representable
    logic             done_buf;
    logic             restart_pend;
    logic             drop_armed;      // last completion kept the buffer the reader ignored

    logic vsync_fall;
    logic wr_elig;
    logic rd_elig;
    logic grant_wr;
    logic grant_rd;
    logic do_restart;
    logic wr_done;
    logic rd_done;
    logic frame_done;
    logic keep_buf;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic buf_sel, input logic [ROW_W-1:0] row);
        burst_addr                    = '0;
        burst_addr[BUF_BIT]           = buf_sel;
        burst_addr[ROW_LSB +: ROW_W]  = row;
    endfunction

    sdram_frame_ctrl_sync_edge_det u_vsync_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (vsync_i),
        .fall_pulse (vsync_fall)
    );

    assign wr_elig    = (wr_fifo_used >= WR_THRESH);
    assign rd_elig    = frame_valid_o && !restart_pend && (rd_row < RD_ROW_END) &&
                        (rd_fifo_used <= RD_THRESH);
    assign wr_done    = (state == WR_REQ) && sdram.wr_sdram_ack;
    assign rd_done    = (state == RD_REQ) && sdram.rd_sdram_ack;
    assign frame_done = wr_done && (wr_row == WR_ROW_LAST);
    // The other buffer is still owned by the reader, so the writer must reuse its own
    assign keep_buf   = frame_valid_o && ((~wr_buf_o) == rd_buf_o);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant arbitration; a pending restart takes a whole IDLE cycle
    always_comb begin
        state_nxt  = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        do_restart = 1'b0;
        case (state)
            IDLE: begin
                if (restart_pend) begin
                    do_restart = 1'b1;
                end else if (wr_elig && rd_elig) begin
                    if (last_grant == GRANT_READ) begin
                        grant_wr = 1'b1;
                    end else begin
                        grant_rd = 1'b1;
                    end
                end else if (wr_elig) begin
                    grant_wr = 1'b1;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr) begin
                    state_nxt = WR_REQ;
                end else if (grant_rd) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_REQ: begin
                if (sdram.wr_sdram_ack) begin
                    state_nxt = IDLE;
                end
            end
            RD_REQ: begin
                if (sdram.rd_sdram_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Requests, row counters, buffer ownership and frame bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram.wr_sdram_req <= 1'b0;
            sdram.wr_sdram_add <= '0;
            sdram.rd_sdram_req <= 1'b0;
            sdram.rd_sdram_add <= '0;
            frame_valid_o      <= 1'b0;
            wr_buf_o           <= 1'b0;
            rd_buf_o           <= 1'b0;
            frame_cnt_o        <= '0;
            drop_o             <= 1'b0;
            last_grant         <= GRANT_READ;
            wr_row             <= '0;
            rd_row             <= '0;
            done_buf           <= 1'b0;
            restart_pend       <= 1'b0;
            drop_armed         <= 1'b0;
        end else begin
            drop_o <= 1'b0;

            if (grant_wr) begin
                sdram.wr_sdram_req <= 1'b1;
                sdram.wr_sdram_add <= burst_addr(wr_buf_o, wr_row);
                last_grant         <= GRANT_WRITE;
            end
            if (grant_rd) begin
                sdram.rd_sdram_req <= 1'b1;
                sdram.rd_sdram_add <= burst_addr(rd_buf_o, rd_row[ROW_W-1:0]);
                last_grant         <= GRANT_READ;
            end

            if (wr_done) begin
                sdram.wr_sdram_req <= 1'b0;
                if (frame_done) begin
                    wr_row        <= '0;
                    done_buf      <= wr_buf_o;
                    frame_valid_o <= 1'b1;
                    frame_cnt_o   <= frame_cnt_o + 16'd1;
                    if (keep_buf) begin
                        drop_o     <= drop_armed;
                        drop_armed <= 1'b1;
                    end else begin
                        wr_buf_o   <= ~wr_buf_o;
                        drop_armed <= 1'b0;
                    end
                end else begin
                    wr_row <= wr_row + ROW_W'(1);
                end
            end

            if (rd_done) begin
                sdram.rd_sdram_req <= 1'b0;
                rd_row             <= rd_row + (ROW_W+1)'(1);
            end

            if (do_restart) begin
                rd_row       <= '0;
                rd_buf_o     <= done_buf;
                restart_pend <= 1'b0;
                drop_armed   <= 1'b0;
            end
            // Placed after the restart clear so an edge in the same cycle is not lost
            if (vsync_fall) begin
                restart_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_frame_ctrl.sv
// tb/tb_sdram_frame_ctrl.sv - directed self-checking bench for sdram_frame_ctrl
module tb_sdram_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] wr_fifo_used;
    logic [10:0] rd_fifo_used;
    logic        vsync_i;
    logic        frame_valid_o;
    logic        wr_buf_o;
    logic        rd_buf_o;
    logic [15:0] frame_cnt_o;
    logic        drop_o;

    int n_cmp      = 0;
    int n_bad      = 0;
    int drop_seen  = 0;
    int both_seen  = 0;

    sdram_frame_ctrl_if #(.ADDR_W(24)) sdram ();

    sdram_frame_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_fifo_used  (wr_fifo_used),
        .rd_fifo_used  (rd_fifo_used),
        .vsync_i       (vsync_i),
        .sdram         (sdram),
        .frame_valid_o (frame_valid_o),
        .wr_buf_o      (wr_buf_o),
        .rd_buf_o      (rd_buf_o),
        .frame_cnt_o   (frame_cnt_o),
        .drop_o        (drop_o)
    );

    always #5 clk = ~clk;

    // Event monitors sampled away from the active edge
    always @(negedge clk) begin
        if (drop_o === 1'b1) drop_seen++;
        if (sdram.wr_sdram_req === 1'b1 && sdram.rd_sdram_req === 1'b1) both_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int t;
        t = 0;
        while (!(sdram.wr_sdram_req === 1'b1 || sdram.rd_sdram_req === 1'b1) && t < 64) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s_req_seen", tag), 32'(sdram.wr_sdram_req | sdram.rd_sdram_req), 32'd1);
    endtask

    task automatic burst(input logic exp_wr, input logic [23:0] exp_add, input int dly, input string tag);
        logic got_wr;
        wait_req(tag);
        if (!(sdram.wr_sdram_req === 1'b1 || sdram.rd_sdram_req === 1'b1)) return;
        got_wr = sdram.wr_sdram_req;
        chk($sformatf("%s_kind", tag), 32'(got_wr), 32'(exp_wr));
        chk($sformatf("%s_add", tag), 32'(got_wr ? sdram.wr_sdram_add : sdram.rd_sdram_add), 32'(exp_add));
        repeat (dly) @(negedge clk);
        chk($sformatf("%s_hold", tag),
            got_wr ? 32'({sdram.wr_sdram_req, sdram.wr_sdram_add}) : 32'({sdram.rd_sdram_req, sdram.rd_sdram_add}),
            32'({1'b1, exp_add}));
        if (got_wr) sdram.wr_sdram_ack = 1'b1;
        else        sdram.rd_sdram_ack = 1'b1;
        @(negedge clk);
        sdram.wr_sdram_ack = 1'b0;
        sdram.rd_sdram_ack = 1'b0;
        chk($sformatf("%s_idle", tag), 32'(sdram.wr_sdram_req | sdram.rd_sdram_req), 32'd0);
    endtask

    task automatic vsync_pulse();
        vsync_i = 1'b0;
        repeat (6) @(negedge clk);
        vsync_i = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n              = 1'b0;
        wr_fifo_used       = 11'd0;
        rd_fifo_used       = 11'd0;
        vsync_i            = 1'b1;
        sdram.wr_sdram_ack = 1'b0;
        sdram.rd_sdram_ack = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_flags", 32'({sdram.wr_sdram_req, sdram.rd_sdram_req, frame_valid_o, wr_buf_o, rd_buf_o, drop_o}), 32'd0);
        chk("rst_wr_add", 32'(sdram.wr_sdram_add), 32'd0);
        chk("rst_rd_add", 32'(sdram.rd_sdram_add), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // One word short of a burst: no write request
        wr_fifo_used = 11'd511;
        repeat (10) @(negedge clk);
        chk("wr_below_thresh", 32'(sdram.wr_sdram_req), 32'd0);

        // Frame 1 into buffer 0; reads blocked only by the empty frame store
        wr_fifo_used = 11'd512;
        for (int i = 0; i < 128; i++) begin
            if (i == 127) chk("fv_before_last_row", 32'(frame_valid_o), 32'd0);
            burst(1'b1, 24'(i << 9), 5, "f1_wr");
        end
        rd_fifo_used = 11'd1023;
        chk("f1_frame_valid", 32'(frame_valid_o), 32'd1);
        chk("f1_frame_cnt", 32'(frame_cnt_o), 32'd1);
        chk("f1_wr_buf", 32'(wr_buf_o), 32'd1);
        burst(1'b1, 24'h400000, 5, "f2_wr_row0");
        wr_fifo_used = 11'd0;

        // Readout of frame 1 after VSYNC
        vsync_pulse();
        chk("rs1_rd_buf", 32'(rd_buf_o), 32'd0);
        rd_fifo_used = 11'd513;
        repeat (10) @(negedge clk);
        chk("rd_above_thresh", 32'(sdram.rd_sdram_req), 32'd0);
        rd_fifo_used = 11'd512;
        for (int i = 0; i < 128; i++) begin
            burst(1'b0, 24'(i << 9), 2, "r1_rd");
        end
        repeat (20) @(negedge clk);
        chk("rd_stop_eof", 32'(sdram.rd_sdram_req), 32'd0);

        // Restart readout, then both sides eligible: strict alternation from WR
        rd_fifo_used = 11'd1023;
        vsync_pulse();
        wr_fifo_used = 11'd512;
        rd_fifo_used = 11'd0;
        burst(1'b1, 24'h400200, 1, "alt_w1");
        burst(1'b0, 24'h000000, 1, "alt_r1");
        burst(1'b1, 24'h400400, 1, "alt_w2");
        burst(1'b0, 24'h000200, 1, "alt_r2");
        burst(1'b1, 24'h400600, 1, "alt_w3");
        burst(1'b0, 24'h000400, 1, "alt_r3");
        rd_fifo_used = 11'd1023;

        // Finish frame 2 while the reader still holds buffer 0
        for (int i = 4; i < 128; i++) begin
            burst(1'b1, 24'h400000 | 24'(i << 9), 2, "f2_wr");
        end
        wr_fifo_used = 11'd0;
        @(negedge clk);
        chk("f2_frame_cnt", 32'(frame_cnt_o), 32'd2);
        chk("f2_wr_buf_kept", 32'(wr_buf_o), 32'd1);
        chk("f2_no_drop", 32'(drop_seen), 32'd0);

        // Frame 3 rewrites buffer 1 without the reader moving
        wr_fifo_used = 11'd512;
        for (int i = 0; i < 128; i++) begin
            burst(1'b1, 24'h400000 | 24'(i << 9), 2, "f3_wr");
        end
        wr_fifo_used = 11'd0;
        @(negedge clk);
        chk("f3_frame_cnt", 32'(frame_cnt_o), 32'd3);
        chk("f3_wr_buf_kept", 32'(wr_buf_o), 32'd1);
        chk("f3_drop_once", 32'(drop_seen), 32'd1);
        chk("f3_rd_buf_held", 32'(rd_buf_o), 32'd0);

        // VSYNC during an in-flight read: restart only after the ack
        rd_fifo_used = 11'd0;
        wait_req("mid_rd");
        chk("mid_rd_kind", 32'(sdram.rd_sdram_req), 32'd1);
        chk("mid_rd_add", 32'(sdram.rd_sdram_add), 32'h000600);
        vsync_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rd_buf_unchanged", 32'(rd_buf_o), 32'd0);
        chk("mid_rd_req_held", 32'(sdram.rd_sdram_req), 32'd1);
        sdram.rd_sdram_ack = 1'b1;
        @(negedge clk);
        sdram.rd_sdram_ack = 1'b0;
        vsync_i = 1'b1;
        burst(1'b0, 24'h400000, 2, "rs_new_frame");
        rd_fifo_used = 11'd1023;
        chk("rs_rd_buf", 32'(rd_buf_o), 32'd1);

        // Asynchronous reset while a write request is outstanding
        wr_fifo_used = 11'd512;
        wait_req("pre_rst");
        chk("pre_rst_wr_req", 32'({sdram.wr_sdram_req, sdram.wr_sdram_add}), 32'({1'b1, 24'h400000}));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", 32'({sdram.wr_sdram_req, sdram.rd_sdram_req, frame_valid_o, wr_buf_o, rd_buf_o, drop_o}), 32'd0);
        chk("async_rst_adds", 32'({sdram.wr_sdram_add[15:0], sdram.rd_sdram_add[15:0]}), 32'd0);
        chk("async_rst_add_hi", 32'({sdram.wr_sdram_add[23:16], sdram.rd_sdram_add[23:16]}), 32'd0);
        chk("async_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        chk("never_both_req", 32'(both_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
